// File: rtl/bank_access_ctrl_pkg.sv
// rtl/bank_access_ctrl_pkg.sv - shared types and constants for the bank access controller
// Purpose: FSM state encoding, statistics counter width, default bus widths and
//   a saturating-increment helper used by the optional statistics counters.
// Ports: none (package).
package bank_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_CAPT  = 2'd2,
    ST_RSP      = 2'd3
  } state_t;

  localparam int STAT_W = 16;

  localparam int DEF_ADR = 8;

  localparam int DEF_DAT = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bank_wq_fifo.sv
// rtl/bank_wq_fifo.sv - write queue with read-address hazard compare
// Purpose: WQ_DEPTH-entry FIFO of pending RAM writes. Flags a hazard when any
//   queued entry, or the entry being pushed this cycle, matches any of the four
//   read addresses.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_addr/data  enqueue (caller guarantees !full)
//   pop                   dequeue head (caller guarantees !empty)
//   rd_addr[3:0]          read lane addresses to compare against
//   full, empty           occupancy flags
//   head_addr, head_data  oldest entry
//   hazard                1 = some lane address matches a pending write
module bank_wq_fifo #(
  parameter int ADR   = 8,
  parameter int DAT   = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [ADR-1:0]      push_addr,
  input  logic [DAT-1:0]      push_data,
  input  logic                pop,
  input  logic [3:0][ADR-1:0] rd_addr,
  output logic                full,
  output logic                empty,
  output logic [ADR-1:0]      head_addr,
  output logic [DAT-1:0]      head_data,
  output logic                hazard
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADR-1:0]   ent_addr [DEPTH];
  logic [DAT-1:0]   ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Per-entry valid bits make occupancy and the hazard compare trivial.
  assign full      = &ent_valid;
  assign empty     = ~|ent_valid;
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= push_addr;
      ent_data[wr_ptr] <= push_data;
    end
  end

  // The head being popped this cycle still counts: the read waits one more
  // cycle rather than racing its own write.
  always_comb begin
    hazard = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (push && push_addr == rd_addr[l]) hazard = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && ent_addr[i] == rd_addr[l]) hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_access_ctrl.sv
// rtl/bank_access_ctrl.sv - cache-bank RAM initiator: write queue plus 4-lane reads
// Purpose: queues writes and drains them one per cycle, issues 4-lane reads with
//   read-after-write ordering, returns data and per-lane unwritten flags via
//   valid/ready. ram_we and ram_re are never asserted together.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   wr_valid/ready, wr_addr/data    write request
//   rd_valid/ready, rd_addr_0..3    4-lane read request
//   rsp_valid/ready, rsp_data_0..3, rsp_unwritten   read response
//   ram_we, ram_waddr, ram_wdata    RAM write port
//   ram_re, ram_raddr_0..3          RAM read port
//   ram_dout_0..3, ram_written      RAM registered read data / unwritten flags
//   stat_rd, stat_wr, stat_stall    saturating counters (BANK_ACCESS_STATS_EN only)
// Configuration macro: BANK_ACCESS_STATS_EN
module bank_access_ctrl
  import bank_access_ctrl_pkg::*;
#(
  parameter int ADR      = DEF_ADR,
  parameter int DAT      = DEF_DAT,
  parameter int WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADR-1:0]    wr_addr,
  input  logic [DAT-1:0]    wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADR-1:0]    rd_addr_0,
  input  logic [ADR-1:0]    rd_addr_1,
  input  logic [ADR-1:0]    rd_addr_2,
  input  logic [ADR-1:0]    rd_addr_3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DAT-1:0]    rsp_data_0,
  output logic [DAT-1:0]    rsp_data_1,
  output logic [DAT-1:0]    rsp_data_2,
  output logic [DAT-1:0]    rsp_data_3,
  output logic [3:0]        rsp_unwritten,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADR-1:0]    ram_waddr,
  output logic [DAT-1:0]    ram_wdata,
  output logic [ADR-1:0]    ram_raddr_0,
  output logic [ADR-1:0]    ram_raddr_1,
  output logic [ADR-1:0]    ram_raddr_2,
  output logic [ADR-1:0]    ram_raddr_3,
  input  logic [DAT-1:0]    ram_dout_0,
  input  logic [DAT-1:0]    ram_dout_1,
  input  logic [DAT-1:0]    ram_dout_2,
  input  logic [DAT-1:0]    ram_dout_3,
  input  logic [3:0]        ram_written
`ifdef BANK_ACCESS_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_rd,
  output logic [STAT_W-1:0] stat_wr,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  state_t               state;
  logic [3:0][ADR-1:0]  rd_addr_v;
  logic [3:0][ADR-1:0]  lat_addr;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic                 hazard;
  logic                 rd_acc;

  assign rd_addr_v = {rd_addr_3, rd_addr_2, rd_addr_1, rd_addr_0};

  assign wr_ready = !full;
  assign push     = wr_valid && !full;

  // Reading only happens in RD_ISSUE, so that is the one state that blocks
  // the drain. Both enables are held low while reset is asserted so nothing
  // queued reaches the RAM once reset has been requested.
  assign ram_re = (state == ST_RD_ISSUE) && !reset;
  assign ram_we = !empty && (state != ST_RD_ISSUE) && !reset;

  // Full blocks reads so the RD_ISSUE bubble cannot starve the drain.
  assign rd_ready = (state == ST_IDLE) && !rsp_valid && !hazard && !full;
  assign rd_acc   = rd_valid && rd_ready;

  assign ram_raddr_0 = lat_addr[0];
  assign ram_raddr_1 = lat_addr[1];
  assign ram_raddr_2 = lat_addr[2];
  assign ram_raddr_3 = lat_addr[3];

  bank_wq_fifo #(
    .ADR   (ADR),
    .DAT   (DAT),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (ram_we),
    .rd_addr   (rd_addr_v),
    .full      (full),
    .empty     (empty),
    .head_addr (ram_waddr),
    .head_data (ram_wdata),
    .hazard    (hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      lat_addr      <= '0;
      rsp_valid     <= 1'b0;
      rsp_data_0    <= '0;
      rsp_data_1    <= '0;
      rsp_data_2    <= '0;
      rsp_data_3    <= '0;
      rsp_unwritten <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_acc) begin
            lat_addr <= rd_addr_v;
            state    <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: state <= ST_RD_CAPT;
        ST_RD_CAPT: begin
          rsp_data_0    <= ram_dout_0;
          rsp_data_1    <= ram_dout_1;
          rsp_data_2    <= ram_dout_2;
          rsp_data_3    <= ram_dout_3;
          rsp_unwritten <= ram_written;
          rsp_valid     <= 1'b1;
          state         <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BANK_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd    <= '0;
      stat_wr    <= '0;
      stat_stall <= '0;
    end else begin
      if (rd_acc)               stat_rd    <= sat_inc(stat_rd);
      if (ram_we)               stat_wr    <= sat_inc(stat_wr);
      if (rd_valid && !rd_ready) stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

  a_we_re_excl: assert property (@(posedge clk) disable iff (reset) !(ram_re && ram_we));

endmodule

// File: tb/tb_bank_access_ctrl.sv
// tb/tb_bank_access_ctrl.sv - self-checking bench for bank_access_ctrl
module tb_bank_access_ctrl;
  localparam int ADR = 8;
  localparam int DAT = 32;
  localparam int WQ  = 4;

  logic clk = 1'b0;
  logic reset, ram_init;
  logic wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [ADR-1:0] wr_addr, rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
  logic [DAT-1:0] wr_data, rsp_data_0, rsp_data_1, rsp_data_2, rsp_data_3;
  logic [3:0] rsp_unwritten, ram_written;
  logic ram_we, ram_re;
  logic [ADR-1:0] ram_waddr, ram_raddr_0, ram_raddr_1, ram_raddr_2, ram_raddr_3;
  logic [DAT-1:0] ram_wdata, ram_dout_0, ram_dout_1, ram_dout_2, ram_dout_3;
`ifdef BANK_ACCESS_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bank_access_ctrl #(.ADR(ADR), .DAT(DAT), .WQ_DEPTH(WQ)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_addr_3(rd_addr_3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1), .rsp_data_2(rsp_data_2), .rsp_data_3(rsp_data_3),
    .rsp_unwritten(rsp_unwritten),
    .ram_we(ram_we), .ram_re(ram_re), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr_0(ram_raddr_0), .ram_raddr_1(ram_raddr_1), .ram_raddr_2(ram_raddr_2), .ram_raddr_3(ram_raddr_3),
    .ram_dout_0(ram_dout_0), .ram_dout_1(ram_dout_1), .ram_dout_2(ram_dout_2), .ram_dout_3(ram_dout_3),
    .ram_written(ram_written)
`ifdef BANK_ACCESS_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_stall(stat_stall)
`endif
  );

  // Bank RAM: registered read data and unwritten flags.
  logic [DAT-1:0] mem [256];
  logic [255:0]   mem_wr;
  always @(posedge clk) begin
    if (ram_init) begin
      mem_wr <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (ram_we) begin
        mem[ram_waddr]    <= ram_wdata;
        mem_wr[ram_waddr] <= 1'b1;
      end
      if (ram_re) begin
        ram_dout_0  <= mem[ram_raddr_0];
        ram_dout_1  <= mem[ram_raddr_1];
        ram_dout_2  <= mem[ram_raddr_2];
        ram_dout_3  <= mem[ram_raddr_3];
        ram_written <= {!mem_wr[ram_raddr_3], !mem_wr[ram_raddr_2], !mem_wr[ram_raddr_1], !mem_wr[ram_raddr_0]};
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending writes as a queue, committed memory image, and
  // the read in flight described by the number of cycles since its acceptance.
  logic [ADR-1:0] pq_a[$];
  logic [DAT-1:0] pq_d[$];
  logic [DAT-1:0] ref_mem [256];
  logic [255:0]   ref_wr;
  logic           busy = 1'b0;
  int             phase = 0;
  logic [ADR-1:0] ra [4], lat_a [4], rr [4];
  logic [DAT-1:0] exp_d [4], rd_v [4];
  logic [3:0]     exp_u;
  int             m_rd = 0, m_wr = 0, m_st = 0;
  logic           full_e, haz, exp_rdy, exp_re, exp_rspv, exp_we;

  always @(negedge clk) begin
    ra[0] = rd_addr_0; ra[1] = rd_addr_1; ra[2] = rd_addr_2; ra[3] = rd_addr_3;
    rr[0] = ram_raddr_0; rr[1] = ram_raddr_1; rr[2] = ram_raddr_2; rr[3] = ram_raddr_3;
    rd_v[0] = rsp_data_0; rd_v[1] = rsp_data_1; rd_v[2] = rsp_data_2; rd_v[3] = rsp_data_3;
    if (reset) begin
      check("m_rst_we", ram_we, 0);
      check("m_rst_re", ram_re, 0);
      pq_a.delete(); pq_d.delete();
      busy = 1'b0; phase = 0; m_rd = 0; m_wr = 0; m_st = 0;
      if (ram_init) begin
        ref_wr = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      end
    end else begin
      full_e = (pq_a.size() == WQ);
      haz = 1'b0;
      for (int l = 0; l < 4; l++) begin
        for (int j = 0; j < pq_a.size(); j++) if (pq_a[j] == ra[l]) haz = 1'b1;
        if (wr_valid && !full_e && wr_addr == ra[l]) haz = 1'b1;
      end
      exp_rdy  = !busy && !full_e && !haz;
      exp_re   = busy && (phase == 1);
      exp_rspv = busy && (phase >= 3);
      exp_we   = (pq_a.size() != 0) && !exp_re;
`ifdef BANK_ACCESS_STATS_EN
      check("m_stat_rd", stat_rd, 64'(m_rd));
      check("m_stat_wr", stat_wr, 64'(m_wr));
      check("m_stat_stall", stat_stall, 64'(m_st));
`endif
      check("m_wr_ready", wr_ready, !full_e);
      check("m_rd_ready", rd_ready, exp_rdy);
      check("m_ram_re", ram_re, exp_re);
      check("m_ram_we", ram_we, exp_we);
      check("m_rsp_valid", rsp_valid, exp_rspv);
      check("m_we_re_excl", ram_we && ram_re, 0);
      if (exp_re) for (int l = 0; l < 4; l++) check("m_raddr", rr[l], lat_a[l]);
      if (exp_rspv) begin
        for (int l = 0; l < 4; l++) check("m_rsp_data", rd_v[l], exp_d[l]);
        check("m_rsp_unwritten", rsp_unwritten, exp_u);
      end
      if (exp_we) begin
        check("m_waddr", ram_waddr, pq_a[0]);
        check("m_wdata", ram_wdata, pq_d[0]);
        ref_mem[pq_a[0]] = pq_d[0];
        ref_wr[pq_a[0]]  = 1'b1;
        void'(pq_a.pop_front());
        void'(pq_d.pop_front());
        m_wr++;
      end
      if (wr_valid && !full_e) begin
        pq_a.push_back(wr_addr);
        pq_d.push_back(wr_data);
      end
      if (rd_valid && !exp_rdy) m_st++;
      if (busy) begin
        if (phase >= 3 && rsp_ready) busy = 1'b0;
        else phase++;
      end
      if (rd_valid && exp_rdy) begin
        busy = 1'b1; phase = 1; m_rd++;
        for (int l = 0; l < 4; l++) begin
          lat_a[l] = ra[l];
          exp_d[l] = ref_mem[ra[l]];
          exp_u[l] = !ref_wr[ra[l]];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr_0 = 8'(a0); rd_addr_1 = 8'(a1); rd_addr_2 = 8'(a2); rd_addr_3 = 8'(a3);
  endtask

  // Called just after the accept sample; returns cycles until rsp_valid is seen.
  task automatic wait_rsp(input string name, output int k);
    k = 0;
    do begin
      cyc(); rd_valid = 1'b0;
      @(negedge clk); k++;
    end while (!rsp_valid && k < 20);
    check(name, rsp_valid, 1);
  endtask

  task automatic consume();
    cyc(); rsp_ready = 1'b1;
    @(negedge clk);
    cyc(); rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int k, we_cnt;
  logic saw_full;
  logic [DAT-1:0] d0;

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_valid = 1'b0; rsp_ready = 1'b0;
    set_rd(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; ram_init = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data0", rsp_data_0, 0);
    check("rst_rsp_unwritten", rsp_unwritten, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_ready", rd_ready, 1);

    // 1: read of untouched lines
    cyc(); rd_valid = 1'b1; set_rd(1, 2, 3, 4);
    @(negedge clk); check("t1_accept", rd_ready, 1);
    wait_rsp("t1_rsp_seen", k);
    check("t1_latency", 64'(k), 3);
    check("t1_unwritten", rsp_unwritten, 4'b1111);
    check("t1_data0", rsp_data_0, 0);
    consume();

    // 2: write then read the same line
    cyc(); wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 32'hA5; rd_valid = 1'b1; set_rd(5, 6, 7, 8);
    @(negedge clk); check("t2_push_hazard", rd_ready, 0);
    cyc(); wr_valid = 1'b0;
    @(negedge clk);
    check("t2_we", ram_we, 1);
    check("t2_waddr", ram_waddr, 5);
    check("t2_queued_hazard", rd_ready, 0);
    cyc();
    @(negedge clk); check("t2_accept", rd_ready, 1);
    wait_rsp("t2_rsp_seen", k);
    check("t2_data0", rsp_data_0, 32'hA5);
    check("t2_unwritten", rsp_unwritten, 4'b1110);
    consume();

    // 3: writes every cycle with a read held -> queue fills
    rsp_ready = 1'b1; rd_valid = 1'b1; set_rd(100, 101, 102, 103); saw_full = 1'b0;
    for (int c = 0; c < 48; c++) begin
      cyc(); wr_valid = 1'b1; wr_addr = 8'(200 + $urandom_range(0, 40)); wr_data = $urandom;
      @(negedge clk);
      if (!wr_ready) begin
        saw_full = 1'b1;
        check("t3_rd_blocked_full", rd_ready, 0);
      end
    end
    check("t3_saw_full", saw_full, 1);
    cyc(); wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (12) cyc();
    rsp_ready = 1'b0;

    // 4: response back-pressure while writes keep draining
    rd_valid = 1'b1; set_rd(9, 10, 11, 12);
    @(negedge clk); check("t4_accept", rd_ready, 1);
    wait_rsp("t4_rsp_seen", k);
    d0 = rsp_data_0; we_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(); rd_valid = 1'b1; set_rd(20, 21, 22, 23);
      wr_valid = 1'b1; wr_addr = 8'(30 + c); wr_data = $urandom;
      @(negedge clk);
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_data_stable", rsp_data_0, d0);
      check("t4_no_accept", rd_ready, 0);
      if (ram_we) we_cnt++;
    end
    check("t4_we_pulses", 64'(we_cnt), 4);
    cyc(); wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    cyc(); rsp_ready = 1'b0;
    repeat (6) cyc();

    // 5: reset during RD_CAPT with two writes queued
    rd_valid = 1'b1; set_rd(40, 41, 42, 43); wr_valid = 1'b1; wr_addr = 8'd50; wr_data = 32'h1111;
    @(negedge clk); check("t5_accept", rd_ready, 1);
    cyc(); rd_valid = 1'b0; wr_addr = 8'd51; wr_data = 32'h2222;
    @(negedge clk);
    check("t5_issue_re", ram_re, 1);
    check("t5_issue_no_we", ram_we, 0);
    cyc(); wr_valid = 1'b0; reset = 1'b1;
    @(negedge clk); check("t5_rst_cycle_we", ram_we, 0);
    cyc(); reset = 1'b0;
    @(negedge clk);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_no_we", ram_we, 0);
    check("t5_wr_ready", wr_ready, 1);
    check("t5_rd_ready", rd_ready, 1);
    cyc();
    @(negedge clk);
    check("t5_no_we2", ram_we, 0);
    check("t5_rsp_valid2", rsp_valid, 0);
    cyc(); rd_valid = 1'b1; set_rd(50, 51, 52, 53);
    @(negedge clk); check("t5_reread_accept", rd_ready, 1);
    wait_rsp("t5_rsp_seen", k);
    check("t5_discarded_unwritten", rsp_unwritten, 4'b1111);
    consume();

    // 6: random traffic
    for (int c = 0; c < 2000; c++) begin
      cyc();
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = 8'($urandom_range(0, 15));
      wr_data   = $urandom;
      rd_valid  = ($urandom_range(0, 99) < 50);
      set_rd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 99) < 60);
    end
    cyc(); wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (12) cyc();
    @(negedge clk);
    check("end_idle_rsp_valid", rsp_valid, 0);
    check("end_idle_we", ram_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
